keccak_perm_ctrl: RTL
=====================

Name: keccak_perm_ctrl

Overview:
Sequencing controller for the 1600-bit Keccak state register and its round-function datapath in the SHAKE/SHA3 core used by the Dilithium engine. It drives the state register's enable and the input-mux select: clear, XOR-absorb of a rate block, round output, or hold. It steps the round index through a full permutation and runs the absorb/squeeze handshake with the upstream message feeder and the downstream output consumer.

Parameters:
NROUNDS, 24, Keccak-f rounds per permutation; legal 1..31.
CNT_W, 16, width of the permutation counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (rst=0 resets)
start  in  1  begin new hash: clear state; honoured only in IDLE or SQUEEZE
blk_valid  in  1  rate block present on datapath absorb input
blk_last  in  1  qualifies blk_valid: final (padded) block
blk_ready  out  1  controller accepts a block this cycle
sq_req  in  1  consumer requests the next output block (one more permutation)
stop  in  1  end squeezing, return to IDLE
st_en  out  1  state register enable
st_sel  out  2  state mux: 00 hold, 01 XOR-absorb, 10 round output, 11 clear-to-zero
round_idx  out  5  current round (round-constant index)
out_valid  out  1  rate part of state valid for squeeze
busy  out  1  high in any state except IDLE
perm_cnt  out  CNT_W  permutations completed since last start, saturating

Behaviour:
- States: IDLE, CLEAR, ABSORB, PERMUTE, SQUEEZE. State, round_idx, last_flag, and perm_cnt are registers.
- Reset (rst=0, async): state=IDLE, round_idx=0, last_flag=0, perm_cnt=0. All outputs 0.
- Outputs decode from registered state. Exception: st_en in ABSORB = blk_valid.
- IDLE: all outputs 0. start=1 -> CLEAR.
- CLEAR (1 cycle): st_en=1, st_sel=11, perm_cnt<=0, last_flag<=0 -> ABSORB.
- ABSORB: blk_ready=1, st_sel=01, st_en=blk_valid.
  - Handshake fires on blk_valid & blk_ready: last_flag<=blk_last, round_idx<=0 -> PERMUTE.
  - No blk_valid: stay, state register holds.
- PERMUTE: st_en=1, st_sel=10 for exactly NROUNDS cycles, round_idx 0..NROUNDS-1.
  - On round_idx=NROUNDS-1: round_idx<=0; perm_cnt<=perm_cnt+1 (saturates at all-ones); next = SQUEEZE if last_flag else ABSORB.
  - blk_ready=0 throughout.
- SQUEEZE: out_valid=1, st_en=0.
  - Priority: start (-> CLEAR) > stop (-> IDLE) > sq_req (-> PERMUTE with round_idx=0; last_flag stays 1, so it returns to SQUEEZE).
- start in ABSORB or PERMUTE is ignored. stop outside SQUEEZE is ignored. sq_req outside SQUEEZE is ignored.
- Latency from start sampled at edge k:
  - CLEAR during cycle k+1.
  - ABSORB from k+2.
  - If a block is accepted at edge t, PERMUTE occupies cycles t+1..t+NROUNDS.
  - The next state (ABSORB or SQUEEZE) is entered at t+NROUNDS+1.
- An async reset mid-permutation aborts immediately. round_idx and perm_cnt go to 0. No partial st_en pulse after rst falls.
- round_idx is zero-extended to 5 bits. It never exceeds NROUNDS-1.

Test Plan:
1. Reset then idle: hold rst=0 for 3 cycles, release, no stimulus for 10 cycles -> all outputs 0, busy=0, st_en never asserted.
2. Single-block hash: start at edge 0; blk_valid=blk_last=1 from cycle 2 -> CLEAR (st_sel=11) in cycle 1; accept at edge 2; st_sel=10 with round_idx 0..23 in cycles 3..26; out_valid=1 from cycle 27; perm_cnt=1.
3. Three-block absorb with 5-cycle gaps between blk_valid pulses -> blk_ready low during each 24-cycle permute; blk_last only on the third block; SQUEEZE after the third permute; perm_cnt=3.
4. Squeeze chain: in SQUEEZE pulse sq_req twice -> two 24-cycle PERMUTE runs, each returning to SQUEEZE; perm_cnt increments by 2; out_valid low during each run.
5. Priority and ignore: in SQUEEZE assert start+stop+sq_req together -> CLEAR next. In PERMUTE assert start at round 10 -> no effect, round_idx continues 11..23.
6. Async reset mid-permute: drop rst at round_idx=7 between clock edges -> outputs 0 immediately, state IDLE; after release, start gives a normal CLEAR cycle.

Source files
------------

// File: rtl/keccak_perm_ctrl.sv
// Sequencing controller for the Keccak-f[1600] state register: clear, absorb, round and squeeze.
// Drives the state enable and input-mux select, and steps the round index through a permutation.
module keccak_perm_ctrl #(
   parameter int unsigned NROUNDS = 24,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             blk_valid,
   input  logic             blk_last,
   output logic             blk_ready,
   input  logic             sq_req,
   input  logic             stop,
   output logic             st_en,
   output logic [1:0]       st_sel,
   output logic [4:0]       round_idx,
   output logic             out_valid,
   output logic             busy,
   output logic [CNT_W-1:0] perm_cnt
);

   localparam logic [1:0] SelHold   = 2'b00;
   localparam logic [1:0] SelAbsorb = 2'b01;
   localparam logic [1:0] SelRound  = 2'b10;
   localparam logic [1:0] SelClear  = 2'b11;
   localparam logic [4:0] LastRound = 5'(NROUNDS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StAbsorb,
      StPermute,
      StSqueeze
   } state_e;

   state_e           state_q, state_d;
   logic [4:0]       round_q, round_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         round_q <= '0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      round_d   = round_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      st_en     = 1'b0;
      st_sel    = SelHold;
      blk_ready = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StClear;
         end
         StClear: begin
            st_en   = 1'b1;
            st_sel  = SelClear;
            cnt_d   = '0;
            last_d  = 1'b0;
            state_d = StAbsorb;
         end
         StAbsorb: begin
            blk_ready = 1'b1;
            st_sel    = SelAbsorb;
            st_en     = blk_valid;
            if (blk_valid) begin
               last_d  = blk_last;
               round_d = '0;
               state_d = StPermute;
            end
         end
         StPermute: begin
            st_en  = 1'b1;
            st_sel = SelRound;
            if (round_q == LastRound) begin
               round_d = '0;
               // Counter saturates rather than wrapping.
               if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
               state_d = last_q ? StSqueeze : StAbsorb;
            end else begin
               round_d = round_q + 5'd1;
            end
         end
         StSqueeze: begin
            out_valid = 1'b1;
            if (start) begin
               state_d = StClear;
            end else if (stop) begin
               state_d = StIdle;
            end else if (sq_req) begin
               round_d = '0;
               state_d = StPermute;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign round_idx = round_q;
   assign busy      = (state_q != StIdle);
   assign perm_cnt  = cnt_q;

endmodule
